// File: rtl/timer_pkg.sv
// timer_pkg: shared encodings for the timer capture/compare block.
//   edge_sel_e  - capture edge select (off / rising / falling / both)
//   cmp_state_e - output-compare FSM states
package timer_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  typedef enum logic {
    CMP_IDLE  = 1'b0,
    CMP_ARMED = 1'b1
  } cmp_state_e;

endpackage

// File: rtl/capture_edge_sync.sv
// capture_edge_sync: brings the asynchronous capture input into the clock
// domain and decodes the selected edge(s) into a one-cycle event.
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   cap_i         - raw asynchronous event input
//   edge_sel_i    - 00 off, 01 rising, 10 falling, 11 both
//   event_o       - one-cycle pulse per selected edge
module capture_edge_sync
  import timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cap_i,
  input  logic [1:0] edge_sel_i,
  output logic       event_o
);

  logic s1_q, s2_q, s3_q;
  logic event_q, event_d;
  logic rise, fall, rise_en, fall_en;

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign rise_en = (edge_sel_i == EDGE_RISE) || (edge_sel_i == EDGE_BOTH);
  assign fall_en = (edge_sel_i == EDGE_FALL) || (edge_sel_i == EDGE_BOTH);

  always_comb begin
    event_d = (rise & rise_en) | (fall & fall_en);
  end

  // The decoded edge is registered so an input change becomes a visible
  // event on the 3rd clock edge after it occurs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      event_q <= 1'b0;
    end else begin
      s1_q    <= cap_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      event_q <= event_d;
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/timer_capture_compare.sv
// timer_capture_compare: input capture and output compare on the free-running
// timer count bus.
// Ports:
//   CLOCK, RESET             - clock, asynchronous active-high reset
//   COUNT                    - current timer value
//   CAP_IN, EDGE_SEL         - async event input and edge select
//   CAP_ACK, OVR_CLR         - capture acknowledge, overrun clear
//   CMP_WR, CMP_STOP         - load+arm compare, disarm compare
//   CMP_VALUE, CMP_PERIOD    - first match value, periodic increment
//   CMP_PERIODIC             - 1 periodic, 0 one-shot
//   CAP_DATA/VALID/OVERRUN   - capture result, valid flag, sticky overrun
//   CMP_MATCH, CMP_ARMED     - one-cycle match pulse, armed status
module timer_capture_compare #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] COUNT,
  input  logic                  CAP_IN,
  input  logic [1:0]            EDGE_SEL,
  input  logic                  CAP_ACK,
  input  logic                  OVR_CLR,
  input  logic                  CMP_WR,
  input  logic                  CMP_STOP,
  input  logic [DATA_WIDTH-1:0] CMP_VALUE,
  input  logic [DATA_WIDTH-1:0] CMP_PERIOD,
  input  logic                  CMP_PERIODIC,
  output logic [DATA_WIDTH-1:0] CAP_DATA,
  output logic                  CAP_VALID,
  output logic                  CAP_OVERRUN,
  output logic                  CMP_MATCH,
  output logic                  CMP_ARMED
);
  import timer_pkg::*;

  logic cap_event;

  capture_edge_sync u_sync (
    .clk_i      (CLOCK),
    .rst_i      (RESET),
    .cap_i      (CAP_IN),
    .edge_sel_i (EDGE_SEL),
    .event_o    (cap_event)
  );

  // Capture path
  logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
  logic                  cap_valid_q, cap_valid_d;
  logic                  cap_ovr_q, cap_ovr_d;

  always_comb begin
    cap_data_d  = cap_data_q;
    cap_valid_d = cap_valid_q;
    cap_ovr_d   = cap_ovr_q & ~OVR_CLR;
    if (cap_event) begin
      // An ack in the same cycle frees the slot, so the new stamp replaces it.
      if (!cap_valid_q || CAP_ACK) begin
        cap_data_d = COUNT;
      end else begin
        cap_ovr_d = 1'b1;
      end
      cap_valid_d = 1'b1;
    end else if (CAP_ACK) begin
      cap_valid_d = 1'b0;
    end
  end

  // Compare path
  cmp_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] count_q;
  logic [DATA_WIDTH-1:0] cmp_reg_q, cmp_reg_d;
  logic [DATA_WIDTH-1:0] per_reg_q, per_reg_d;
  logic                  periodic_q, periodic_d;
  logic                  match_q, match_d;
  logic                  hit;

  // Only the cycle the count arrives at the value counts as a hit.
  assign hit = (COUNT == cmp_reg_q) && (COUNT != count_q);

  always_comb begin
    state_d    = state_q;
    cmp_reg_d  = cmp_reg_q;
    per_reg_d  = per_reg_q;
    periodic_d = periodic_q;
    match_d    = 1'b0;
    if (CMP_STOP) begin
      state_d = timer_pkg::CMP_IDLE;
    end else if (CMP_WR) begin
      state_d    = timer_pkg::CMP_ARMED;
      cmp_reg_d  = CMP_VALUE;
      per_reg_d  = CMP_PERIOD;
      periodic_d = CMP_PERIODIC;
    end else if (state_q == timer_pkg::CMP_ARMED && hit) begin
      match_d = 1'b1;
      if (periodic_q && (per_reg_q != '0)) begin
        cmp_reg_d = cmp_reg_q + per_reg_q;
      end else begin
        state_d = timer_pkg::CMP_IDLE;
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
      cap_ovr_q   <= 1'b0;
      state_q     <= timer_pkg::CMP_IDLE;
      count_q     <= '0;
      cmp_reg_q   <= '0;
      per_reg_q   <= '0;
      periodic_q  <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      cap_data_q  <= cap_data_d;
      cap_valid_q <= cap_valid_d;
      cap_ovr_q   <= cap_ovr_d;
      state_q     <= state_d;
      count_q     <= COUNT;
      cmp_reg_q   <= cmp_reg_d;
      per_reg_q   <= per_reg_d;
      periodic_q  <= periodic_d;
      match_q     <= match_d;
    end
  end

  assign CAP_DATA    = cap_data_q;
  assign CAP_VALID   = cap_valid_q;
  assign CAP_OVERRUN = cap_ovr_q;
  assign CMP_MATCH   = match_q;
  assign CMP_ARMED   = (state_q == timer_pkg::CMP_ARMED);

endmodule

// File: tb/tb_timer_capture_compare.sv
module tb_timer_capture_compare;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] COUNT = '0;
  logic        CAP_IN = 1'b0;
  logic [1:0]  EDGE_SEL = 2'b01;
  logic        CAP_ACK = 1'b0;
  logic        OVR_CLR = 1'b0;
  logic        CMP_WR = 1'b0;
  logic        CMP_STOP = 1'b0;
  logic [15:0] CMP_VALUE = '0;
  logic [15:0] CMP_PERIOD = '0;
  logic        CMP_PERIODIC = 1'b0;
  logic [15:0] CAP_DATA;
  logic        CAP_VALID;
  logic        CAP_OVERRUN;
  logic        CMP_MATCH;
  logic        CMP_ARMED;

  timer_capture_compare #(.DATA_WIDTH(16)) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .COUNT        (COUNT),
    .CAP_IN       (CAP_IN),
    .EDGE_SEL     (EDGE_SEL),
    .CAP_ACK      (CAP_ACK),
    .OVR_CLR      (OVR_CLR),
    .CMP_WR       (CMP_WR),
    .CMP_STOP     (CMP_STOP),
    .CMP_VALUE    (CMP_VALUE),
    .CMP_PERIOD   (CMP_PERIOD),
    .CMP_PERIODIC (CMP_PERIODIC),
    .CAP_DATA     (CAP_DATA),
    .CAP_VALID    (CAP_VALID),
    .CAP_OVERRUN  (CAP_OVERRUN),
    .CMP_MATCH    (CMP_MATCH),
    .CMP_ARMED    (CMP_ARMED)
  );

  always #5 CLOCK = ~CLOCK;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Capture: a CAP_IN transition seen at clock edge k is qualified by
  // EDGE_SEL at edge k+2 and stamps COUNT at edge k+3.
  logic        m_prev;
  logic [1:0]  m_tr1, m_tr2;   // {fall, rise} seen 1 and 2 edges ago
  logic        m_ev, ev_use;
  logic [15:0] m_data;
  logic        m_valid, m_ovr, m_ovr_set;
  // Compare
  logic        m_armed, m_periodic, m_match, entered;
  logic [15:0] m_tgt, m_per, m_prev_cnt;

  always begin
    @(posedge CLOCK);
    if (RESET) begin
      m_prev = 0; m_tr1 = 0; m_tr2 = 0; m_ev = 0;
      m_data = 0; m_valid = 0; m_ovr = 0;
      m_armed = 0; m_periodic = 0; m_match = 0;
      m_tgt = 0; m_per = 0; m_prev_cnt = 0;
    end else begin
      ev_use = m_ev;
      m_ev   = (m_tr2[0] & EDGE_SEL[0]) | (m_tr2[1] & EDGE_SEL[1]);
      m_tr2  = m_tr1;
      m_tr1  = {m_prev & ~CAP_IN, CAP_IN & ~m_prev};
      m_prev = CAP_IN;
      m_ovr_set = 0;
      if (ev_use) begin
        if (!m_valid || CAP_ACK) m_data = COUNT;
        else m_ovr_set = 1;
        m_valid = 1;
      end else if (CAP_ACK) begin
        m_valid = 0;
      end
      m_ovr = (m_ovr && !OVR_CLR) || m_ovr_set;

      entered = (COUNT == m_tgt) && (COUNT != m_prev_cnt);
      m_match = 0;
      if (CMP_STOP) m_armed = 0;
      else if (CMP_WR) begin
        m_armed = 1; m_tgt = CMP_VALUE; m_per = CMP_PERIOD; m_periodic = CMP_PERIODIC;
      end else if (m_armed && entered) begin
        m_match = 1;
        if (m_periodic && m_per != 0) m_tgt = m_tgt + m_per;
        else m_armed = 0;
      end
      m_prev_cnt = COUNT;
    end
    #1;
    chk("cyc CAP_DATA", CAP_DATA, m_data);
    chk("cyc CAP_VALID", CAP_VALID, m_valid);
    chk("cyc CAP_OVERRUN", CAP_OVERRUN, m_ovr);
    chk("cyc CMP_MATCH", CMP_MATCH, m_match);
    chk("cyc CMP_ARMED", CMP_ARMED, m_armed);
  end

  // ---------------- stimulus ----------------
  logic cnt_run = 1'b1;

  task automatic cyc();
    @(negedge CLOCK);
    if (cnt_run) COUNT = COUNT + 16'd1;
  endtask

  task automatic wait_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_cnt(input logic [15:0] tgt, input string nm);
    int unsigned n = 0;
    while (COUNT != tgt && n < 300) begin cyc(); n++; end
    chk(nm, COUNT, tgt);
  endtask

  task automatic arm(input logic [15:0] start, input logic [15:0] val,
                     input logic [15:0] per, input logic periodic);
    COUNT = start; CMP_VALUE = val; CMP_PERIOD = per; CMP_PERIODIC = periodic;
    CMP_WR = 1; cyc(); CMP_WR = 0;
  endtask

  task automatic ack();
    CAP_ACK = 1; cyc(); CAP_ACK = 0;
  endtask

  logic [15:0] c1, c3, c5;

  initial begin
    #1;
    chk("reset CAP_DATA", CAP_DATA, 16'h0);
    chk("reset CAP_VALID", CAP_VALID, 0);
    chk("reset CMP_ARMED", CMP_ARMED, 0);
    wait_n(3);
    RESET = 0;
    wait_n(3);

    // Capture timing
    COUNT = 16'h0010; CAP_IN = 1;
    wait_n(3);
    chk("cap not yet valid", CAP_VALID, 0);
    cyc();
    chk("cap stamp", CAP_DATA, 16'h0013);
    chk("cap valid", CAP_VALID, 1);
    ack();
    chk("ack clears valid", CAP_VALID, 0);

    // Overrun
    CAP_IN = 0; wait_n(3);
    c1 = COUNT; CAP_IN = 1; wait_n(2);
    CAP_IN = 0; wait_n(8);
    CAP_IN = 1; wait_n(4);
    chk("ovr keeps first", CAP_DATA, c1 + 16'd3);
    chk("ovr set", CAP_OVERRUN, 1);
    OVR_CLR = 1; cyc(); OVR_CLR = 0;
    chk("ovr cleared", CAP_OVERRUN, 0);
    CAP_IN = 0; wait_n(3);
    c3 = COUNT; CAP_IN = 1; wait_n(3);
    CAP_ACK = 1; cyc(); CAP_ACK = 0;
    chk("ack+event reload", CAP_DATA, c3 + 16'd3);
    chk("ack+event valid", CAP_VALID, 1);
    chk("ack+event no ovr", CAP_OVERRUN, 0);
    ack();

    // Both edges, then off
    CAP_IN = 0; wait_n(4);
    EDGE_SEL = 2'b11; wait_n(2);
    c5 = COUNT; CAP_IN = 1; wait_n(4);
    chk("both rise stamp", CAP_DATA, c5 + 16'd3);
    ack();
    CAP_IN = 0; wait_n(3);
    chk("both gap", CAP_VALID, 0);
    cyc();
    chk("both fall stamp", CAP_DATA, c5 + 16'd8);
    chk("both fall valid", CAP_VALID, 1);
    ack();
    EDGE_SEL = 2'b00; CAP_IN = 1; wait_n(6);
    CAP_IN = 0; wait_n(6);
    chk("edge off no cap", CAP_VALID, 0);
    EDGE_SEL = 2'b01;

    // One-shot compare
    arm(16'h0010, 16'h0020, 16'h0, 0);
    chk("oneshot armed", CMP_ARMED, 1);
    wait_cnt(16'h0020, "wait 0x20");
    cyc();
    chk("oneshot match", CMP_MATCH, 1);
    chk("oneshot disarm", CMP_ARMED, 0);
    cyc();
    chk("oneshot pulse end", CMP_MATCH, 0);

    // Stalled count at match value
    arm(16'h0018, 16'h0020, 16'h0, 0);
    wait_cnt(16'h0020, "wait 0x20 hold");
    cnt_run = 0; cyc();
    chk("hold match", CMP_MATCH, 1);
    for (int i = 0; i < 3; i++) begin cyc(); chk("hold single", CMP_MATCH, 0); end

    // Re-arm onto the value the stalled count already sits at
    COUNT = 16'h0040; cyc();
    arm(16'h0040, 16'h0040, 16'h0, 0);
    chk("stall armed", CMP_ARMED, 1);
    for (int i = 0; i < 3; i++) begin cyc(); chk("stall no match", CMP_MATCH, 0); end
    cnt_run = 1;
    CMP_STOP = 1; cyc(); CMP_STOP = 0;

    // Counter jump to zero with target zero
    arm(16'h0050, 16'h0000, 16'h0, 0);
    COUNT = 16'h0000; cyc();
    chk("jump to 0 match", CMP_MATCH, 1);

    // Periodic with wrap
    arm(16'hFFE8, 16'hFFF0, 16'h0020, 1);
    wait_cnt(16'hFFF0, "wait FFF0");
    cyc();
    chk("per match1", CMP_MATCH, 1);
    chk("per still armed", CMP_ARMED, 1);
    wait_cnt(16'h0010, "wait 0010");
    cyc();
    chk("per wrap match", CMP_MATCH, 1);
    CMP_STOP = 1; cyc(); CMP_STOP = 0;
    chk("per stopped", CMP_ARMED, 0);

    // Periodic with zero period
    arm(16'h0100, 16'h0105, 16'h0, 1);
    wait_cnt(16'h0105, "wait 0105");
    cyc();
    chk("per0 match", CMP_MATCH, 1);
    chk("per0 idle", CMP_ARMED, 0);

    // Stop coincident with hit
    arm(16'h01F0, 16'h0200, 16'h0, 0);
    wait_cnt(16'h0200, "wait 0200");
    CMP_STOP = 1; cyc(); CMP_STOP = 0;
    chk("stop+hit no pulse", CMP_MATCH, 0);
    chk("stop+hit idle", CMP_ARMED, 0);

    // Write coincident with hit
    arm(16'h02F0, 16'h0300, 16'h0, 0);
    wait_cnt(16'h0300, "wait 0300");
    CMP_WR = 1; cyc(); CMP_WR = 0;
    chk("wr+hit no pulse", CMP_MATCH, 0);
    chk("wr+hit armed", CMP_ARMED, 1);
    CMP_STOP = 1; cyc(); CMP_STOP = 0;

    // Async reset while armed and holding a capture
    arm(16'h6000, 16'h7000, 16'h0, 0);
    CAP_IN = 1; wait_n(5);
    chk("pre-rst valid", CAP_VALID, 1);
    chk("pre-rst armed", CMP_ARMED, 1);
    RESET = 1; #1;
    chk("rst CAP_DATA", CAP_DATA, 16'h0);
    chk("rst CAP_VALID", CAP_VALID, 0);
    chk("rst CAP_OVERRUN", CAP_OVERRUN, 0);
    chk("rst CMP_MATCH", CMP_MATCH, 0);
    chk("rst CMP_ARMED", CMP_ARMED, 0);
    wait_n(2);
    CAP_IN = 0; cyc();
    RESET = 0; wait_n(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
